gfx_dma_queue: RTL and testbench

// - Command queue + sequencer in front of GfxDma: CPU stages 8-byte blit descriptors, commits them into a FIFO.
// - Sequencer pops one descriptor at a time, writes DMA regs 0x0..0x7 (STATE last = start), waits for completion, repeats.
// - Sits between CPU bus decode and the GfxDma control port; CPU never writes GfxDma registers directly.

---
 rtl/gfx_dma_queue_pkg.sv | 32 +++
 rtl/gfx_dma_queue_if.sv | 27 ++
 rtl/gfx_dma_desc_fifo.sv | 72 +++++++
 rtl/gfx_dma_queue.sv | 199 +++++++++++++++++++
 tb/tb_gfx_dma_queue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_dma_queue_pkg.sv
// ============================================================================
// gfx_dma_queue_pkg : shared types, CPU address map and DMA register indices
// Revision: 1.0
// ============================================================================
`default_nettype none

package gfx_dma_queue_pkg;

    localparam int unsigned DESC_W = 64;

    localparam logic [2:0] DMA_REG_FIRST = 3'h0;
    localparam logic [2:0] DMA_REG_STATE = 3'h7;

    localparam logic [3:0] CPU_ADDR_COMMIT  = 4'h8;
    localparam logic [3:0] CPU_ADDR_CLR_ERR = 4'h9;
    localparam logic [3:0] CPU_ADDR_FLUSH   = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQ        = 3'd1,
        S_WRITE      = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4
    } seq_state_e;

    function automatic logic [2:0] sat_count3(input logic [7:0] cnt);
        return (cnt > 8'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gfx_dma_queue_if.sv
// ============================================================================
// gfx_dma_queue_if : bus request/grant and GfxDma control port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gfx_dma_queue_if;
    logic       bus_req;
    logic       bus_gnt;
    logic       dma_ce_b;
    logic       dma_we_b;
    logic [2:0] dma_addr;
    logic [7:0] dma_data;
    logic       dma_active;

    modport master (
        output bus_req, dma_ce_b, dma_we_b, dma_addr, dma_data,
        input  bus_gnt, dma_active
    );

    modport slave (
        input  bus_req, dma_ce_b, dma_we_b, dma_addr, dma_data,
        output bus_gnt, dma_active
    );
endinterface

`default_nettype wire

// File: rtl/gfx_dma_desc_fifo.sv
// ============================================================================
// gfx_dma_desc_fifo : synchronous descriptor FIFO with push/pop/flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module gfx_dma_desc_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned WIDTH      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic                  i_flush_keep_head,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_keep;

    assign o_full    = (count_q == CNT_W'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_head    = mem_q[rd_ptr_q];
    assign w_push_ok = i_push && !o_full && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_keep    = i_flush_keep_head && !w_pop_ok && !o_empty;

    // A flush that keeps the head leaves exactly the entry being programmed.
    always_comb begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(w_pop_ok);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(w_push_ok);
        count_d  = count_q + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        if (i_flush) begin
            wr_ptr_d = rd_ptr_d + DEPTH_LOG2'(w_keep);
            count_d  = CNT_W'(w_keep);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end
endmodule

`default_nettype wire

// File: rtl/gfx_dma_queue.sv
// ============================================================================
// gfx_dma_queue : CPU descriptor staging, command FIFO and GfxDma sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module gfx_dma_queue
    import gfx_dma_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2    = 2,
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cpu_wr,
    input  logic [3:0]      i_cpu_addr,
    input  logic [7:0]      i_cpu_data,
    output logic [7:0]      o_status,
    output logic            o_irq,
    gfx_dma_queue_if.master dma_bus
);
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [7:0]        stage_q [8];
    logic [DESC_W-1:0] w_stage_word;
    logic [DESC_W-1:0] w_head;
    logic              w_full, w_empty, w_pop, w_keep, w_set_tmo;
    logic [CNT_W-1:0]  w_count;
    logic              w_stage_wr, w_commit, w_clr_err, w_flush;
    logic [2:0]        w_next_idx, w_sel;
    logic [7:0]        w_head_byte;

    seq_state_e        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [3:0]        timer_q, timer_d;
    logic              bus_req_q, bus_req_d;
    logic              ce_b_q, ce_b_d, we_b_q, we_b_d;
    logic [2:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              irq_q, irq_d;
    logic              err_ovf_q, err_tmo_q;

    assign w_stage_wr = i_cpu_wr && !i_cpu_addr[3];
    assign w_commit   = i_cpu_wr && (i_cpu_addr == CPU_ADDR_COMMIT);
    assign w_clr_err  = i_cpu_wr && (i_cpu_addr == CPU_ADDR_CLR_ERR);
    assign w_flush    = i_cpu_wr && (i_cpu_addr == CPU_ADDR_FLUSH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) stage_q[i] <= '0;
        end else if (w_stage_wr) begin
            stage_q[i_cpu_addr[2:0]] <= i_cpu_data;
        end
    end

    always_comb begin
        w_stage_word = '0;
        for (int i = 0; i < 8; i++) w_stage_word[8*i +: 8] = stage_q[i];
    end

    // The head stays in the FIFO while it is being programmed, so a flush
    // in REQ/WRITE must spare it.
    assign w_keep = ((state_q == S_REQ) || (state_q == S_WRITE)) && !w_pop;

    gfx_dma_desc_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DESC_W)
    ) u_fifo (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_push            (w_commit),
        .i_push_data       (w_stage_word),
        .i_pop             (w_pop),
        .i_flush           (w_flush),
        .i_flush_keep_head (w_keep),
        .o_head            (w_head),
        .o_full            (w_full),
        .o_empty           (w_empty),
        .o_count           (w_count)
    );

    assign w_next_idx  = idx_q + 3'd1;
    assign w_sel       = (state_q == S_WRITE) ? w_next_idx : DMA_REG_FIRST;
    assign w_head_byte = w_head[{w_sel, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        bus_req_d = bus_req_q;
        ce_b_d    = 1'b1;
        we_b_d    = 1'b1;
        addr_d    = addr_q;
        data_d    = data_q;
        irq_d     = 1'b0;
        w_pop     = 1'b0;
        w_set_tmo = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((!w_empty || w_commit) && !w_flush && !dma_bus.dma_active) begin
                    state_d   = S_REQ;
                    bus_req_d = 1'b1;
                end
            end
            S_REQ: begin
                if (dma_bus.bus_gnt) begin
                    state_d = S_WRITE;
                    idx_d   = DMA_REG_FIRST;
                    ce_b_d  = 1'b0;
                    we_b_d  = 1'b0;
                    addr_d  = DMA_REG_FIRST;
                    data_d  = w_head_byte;
                end
            end
            S_WRITE: begin
                if (idx_q == DMA_REG_STATE) begin
                    state_d   = S_WAIT_START;
                    bus_req_d = 1'b0;
                    w_pop     = 1'b1;
                    timer_d   = '0;
                end else begin
                    idx_d  = w_next_idx;
                    ce_b_d = 1'b0;
                    we_b_d = 1'b0;
                    addr_d = w_next_idx;
                    data_d = w_head_byte;
                end
            end
            S_WAIT_START: begin
                if (dma_bus.dma_active) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == 4'(START_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    w_set_tmo = 1'b1;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!dma_bus.dma_active) begin
                    state_d = S_IDLE;
                    irq_d   = w_empty && !w_commit;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            bus_req_q <= 1'b0;
            ce_b_q    <= 1'b1;
            we_b_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            bus_req_q <= bus_req_d;
            ce_b_q    <= ce_b_d;
            we_b_q    <= we_b_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            irq_q     <= irq_d;
        end
    end

    // Setting an error wins over a clear landing in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_ovf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            if (w_clr_err) begin
                err_ovf_q <= 1'b0;
                err_tmo_q <= 1'b0;
            end
            if (w_commit && w_full) err_ovf_q <= 1'b1;
            if (w_set_tmo)          err_tmo_q <= 1'b1;
        end
    end

    assign o_status = {err_ovf_q, err_tmo_q, (state_q != S_IDLE), w_full, w_empty,
                       sat_count3(8'(w_count))};
    assign o_irq    = irq_q;

    assign dma_bus.bus_req  = bus_req_q;
    assign dma_bus.dma_ce_b = ce_b_q;
    assign dma_bus.dma_we_b = we_b_q;
    assign dma_bus.dma_addr = addr_q;
    assign dma_bus.dma_data = data_q;
endmodule

`default_nettype wire

// File: tb/tb_gfx_dma_queue.sv
// ============================================================================
// tb_gfx_dma_queue : scoreboard bench for gfx_dma_queue with DMA/arbiter models
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gfx_dma_queue;
    localparam int TMO   = 15;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_wr = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic [7:0] cpu_data = '0;
    logic [7:0] status;
    logic       irq;
    logic       gnt_tie = 1'b0, gnt_q = 1'b0, force_active = 1'b0, dma_act = 1'b0;
    int         gnt_delay = 0, start_dly = 2, hold = 3;
    bit         dma_respond = 1'b1;

    gfx_dma_queue_if bus ();
    assign bus.bus_gnt    = gnt_tie | gnt_q;
    assign bus.dma_active = force_active | dma_act;

    gfx_dma_queue #(.DEPTH_LOG2(2), .START_TIMEOUT(TMO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cpu_wr   (cpu_wr),
        .i_cpu_addr (cpu_addr),
        .i_cpu_data (cpu_data),
        .o_status   (status),
        .o_irq      (irq),
        .dma_bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: queue of committed descriptors plus the CPU staging bytes
    logic [63:0] model_q [$];
    logic [7:0]  stg [8];
    logic [63:0] mon_head;
    bit exp_ovf = 0, exp_tmo = 0, inflight = 0, post7 = 0, prev_req = 0, prev_tmo = 0;
    int exp_idx = 0, irq_cnt = 0, t_req = 0, t_w0 = 0, t_w7 = 0, t_commit = 0, last_push_cyc = -1;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_stage();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = stg[i];
        return d;
    endfunction

    task automatic model_reset();
        model_q.delete();
        for (int i = 0; i < 8; i++) stg[i] = 8'h00;
        exp_ovf = 0; exp_tmo = 0; inflight = 0; post7 = 0; exp_idx = 0;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_addr = a; cpu_data = d;
        if (a < 4'h8) begin
            stg[a[2:0]] = d;
        end else if (a == 4'h8) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(pack_stage());
                t_commit = cyc;
                last_push_cyc = cyc;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (a == 4'h9) begin
            exp_ovf = 1'b0; exp_tmo = 1'b0;
        end else if (a == 4'hA) begin
            if (inflight) begin
                while (model_q.size() > 1) void'(model_q.pop_back());
            end else begin
                model_q.delete();
            end
        end
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic commit_desc(input logic [7:0] b0);
        cpu_write(4'h0, b0);
        cpu_write(4'h8, 8'h00);
    endtask

    task automatic check_status(input string name);
        int sz;
        @(negedge clk);
        sz = model_q.size();
        chk(name, 64'({status[7:6], status[4:0]}),
            64'({exp_ovf, exp_tmo, (sz == DEPTH), (sz == 0), 3'(sz)}));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(model_q.size() == 0 && !status[5] && !bus.dma_active) && n < 3000);
        chk(name, 64'(n < 3000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every register write is matched against the head of the model queue
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.bus_req && !prev_req) t_req = cyc;
            if (post7) begin
                chk("req_drop_after_state", 64'(bus.bus_req), 64'd0);
                post7 = 0;
            end
            if (!bus.dma_ce_b || !bus.dma_we_b) begin
                chk("ce_we_together", 64'(bus.dma_we_b), 64'(bus.dma_ce_b));
                chk("grant_during_write", 64'({bus.bus_req, bus.bus_gnt}), 64'b11);
                chk("no_write_while_active", 64'(bus.dma_active), 64'd0);
                chk("write_expected", 64'(model_q.size() != 0), 64'd1);
                if (model_q.size() != 0) begin
                    mon_head = model_q[0];
                    chk("write_addr", 64'(bus.dma_addr), 64'(exp_idx));
                    chk("write_data", 64'(bus.dma_data), 64'(mon_head[8*exp_idx +: 8]));
                    if (exp_idx == 0) begin
                        inflight = 1; t_w0 = cyc;
                    end
                    if (exp_idx == 7) begin
                        void'(model_q.pop_front());
                        inflight = 0; t_w7 = cyc; post7 = 1; exp_idx = 0;
                    end else begin
                        exp_idx++;
                    end
                end
            end
            if (irq) begin
                irq_cnt++;
                chk("irq_fifo_empty", 64'(model_q.size() - int'(last_push_cyc == cyc)), 64'd0);
            end
            // STATE write cycle, then START_TIMEOUT cycles of waiting, then the flag
            if (status[6] && !prev_tmo) chk("tmo_latency", 64'(cyc - t_w7), 64'(TMO + 1));
            prev_req = bus.bus_req;
            prev_tmo = status[6];
        end
    end

    // Bus arbiter model: grant after gnt_delay cycles, released when request drops
    initial forever begin
        @(negedge clk);
        if (bus.bus_req && !gnt_q) begin
            repeat (gnt_delay) @(posedge clk);
            #1 gnt_q = 1'b1;
        end else if (!bus.bus_req && gnt_q) begin
            gnt_q = 1'b0;
        end
    end

    // GfxDma model: starts start_dly cycles after the STATE write, busy for hold cycles
    initial forever begin
        @(negedge clk);
        if (!rst && !bus.dma_ce_b && bus.dma_addr == 3'd7 && dma_respond) begin
            repeat (start_dly) @(posedge clk);
            #1 dma_act = 1'b1;
            repeat (hold) @(posedge clk);
            #1 dma_act = 1'b0;
        end
    end

    initial begin
        int irq0, n, nb;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({bus.bus_req, bus.dma_ce_b, bus.dma_we_b, bus.dma_addr, bus.dma_data, irq}),
            64'({1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 1'b0}));
        chk("reset_status", 64'(status), 64'h08);
        @(posedge clk); #1 rst = 1'b0;

        // Basic blit with grant tied high, latency from COMMIT
        gnt_tie = 1'b1; irq0 = irq_cnt;
        for (int i = 0; i < 8; i++) cpu_write(4'(i), 8'(11 + i));
        cpu_write(4'h8, 8'h00);
        wait_idle("t1_drain");
        chk("t1_req_latency",   64'(t_req - t_commit), 64'd1);
        chk("t1_first_write",   64'(t_w0 - t_commit), 64'd2);
        chk("t1_state_write",   64'(t_w7 - t_commit), 64'd9);
        chk("t1_irq_count",     64'(irq_cnt - irq0), 64'd1);

        // Overflow while the DMA is held busy
        force_active = 1'b1; irq0 = irq_cnt;
        for (int k = 0; k < 5; k++) commit_desc(8'(8'h40 + k));
        check_status("t2_full_ovf");
        chk("t2_not_busy", 64'(status[5]), 64'd0);
        cpu_write(4'h9, 8'h00);
        check_status("t2_clr_err");
        force_active = 1'b0;
        wait_idle("t2_drain");
        chk("t2_irq_count", 64'(irq_cnt - irq0), 64'd1);

        // Three back-to-back descriptors with a long DMA busy time
        gnt_tie = 1'b0; gnt_delay = 1; hold = 20; irq0 = irq_cnt;
        for (int k = 0; k < 3; k++) commit_desc(8'(8'h80 + k));
        wait_idle("t3_drain");
        chk("t3_irq_count", 64'(irq_cnt - irq0), 64'd1);

        // Start timeout: DMA never goes active
        dma_respond = 1'b0; hold = 3; gnt_delay = 0; irq0 = irq_cnt;
        commit_desc(8'hA1);
        commit_desc(8'hA2);
        wait_idle("t4_drain");
        exp_tmo = 1'b1;
        check_status("t4_tmo_set");
        chk("t4_irq_count", 64'(irq_cnt - irq0), 64'd0);
        cpu_write(4'h9, 8'h00);
        dma_respond = 1'b1;
        check_status("t4_tmo_clr");

        // Delayed grant
        gnt_delay = 6;
        commit_desc(8'hB7);
        wait_idle("t5_drain");
        chk("t5_grant_to_write", 64'(t_w0 - t_req), 64'd7);

        // Reset in the middle of programming (register index 3)
        gnt_delay = 0; gnt_tie = 1'b1;
        commit_desc(8'hC3);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(!bus.dma_ce_b && bus.dma_addr == 3'd2) && n < 100);
        chk("t6_reached_idx2", 64'(n < 100), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t6_reset_bus", 64'({bus.bus_req, bus.dma_ce_b, bus.dma_we_b}), 64'b011);
        chk("t6_reset_status", 64'(status), 64'h08);

        // Flush while a blit is in WAIT_DONE with two more queued
        hold = 40; irq0 = irq_cnt;
        commit_desc(8'hD0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.dma_active && n < 100);
        chk("t7_dma_started", 64'(n < 100), 64'd1);
        commit_desc(8'hD1);
        commit_desc(8'hD2);
        check_status("t7_two_queued");
        cpu_write(4'hA, 8'h00);
        check_status("t7_flushed");
        wait_idle("t7_drain");
        chk("t7_irq_count", 64'(irq_cnt - irq0), 64'd1);
        gnt_tie = 1'b0;

        // Randomized traffic: partial restaging, random grant and DMA timing
        for (int it = 0; it < 40; it++) begin
            gnt_delay = $urandom_range(0, 3);
            start_dly = $urandom_range(1, 4);
            hold      = $urandom_range(1, 8);
            nb        = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) cpu_write(4'($urandom_range(0, 7)), 8'($urandom));
            if (model_q.size() < DEPTH) cpu_write(4'h8, 8'h00);
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle("t8_drain");
        check_status("t8_final_status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
